// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The state enum, the datapath widths and the PC alignment helper live here.

package fetch_pkg;

    localparam int PC_W        = 64;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    // Low address bits that select a byte inside one instruction word
    localparam logic [PC_W-1:0] PC_LOW_MASK = PC_W'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    function automatic logic [PC_W-1:0] alignPc(input logic [PC_W-1:0] pc);
        return pc & ~PC_LOW_MASK;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: a valid bit plus the instruction word and its address.
// A flush beats a load, and a load beats a hold.

module if_id_reg
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_flush,
    input  logic               i_load,
    input  logic               i_stall,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;

    // Draining with nothing new only clears valid; instr/pc keep their last value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (!i_stall) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory read at a time and
// feeds the IF/ID register, absorbing memory latency, decode stalls and redirects.

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
)
(
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_d,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc
);

    fetch_state_t       r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_kill;
    logic [INSTR_W-1:0] r_bufInstr;
    logic [PC_W-1:0]    r_bufPc;

    logic [PC_W-1:0]    w_redirPc;
    logic [PC_W-1:0]    w_pcInc;
    logic               w_ifIdFree;
    logic               w_respLive;
    logic               w_loadFromMem;
    logic               w_loadFromBuf;
    logic               w_load;
    logic [INSTR_W-1:0] w_loadInstr;
    logic [PC_W-1:0]    w_loadPc;

    assign w_redirPc = alignPc(redirect_pc);
    assign w_pcInc   = r_pc + PC_W'(INSTR_BYTES);

    // Reset gating keeps the request quiet while the stage is held in reset
    assign imem_req  = reset_n && (r_state == ISSUE) && !redirect;
    assign imem_addr = r_pc;

    assign w_ifIdFree    = !if_valid || !stall_d;
    assign w_respLive    = (r_state == WAIT) && imem_rvalid && !redirect && !r_kill;
    assign w_loadFromMem = w_respLive && w_ifIdFree;
    assign w_loadFromBuf = (r_state == HOLD) && !redirect && !stall_d;
    assign w_load        = w_loadFromMem || w_loadFromBuf;
    assign w_loadInstr   = w_loadFromBuf ? r_bufInstr : imem_rdata;
    assign w_loadPc      = w_loadFromBuf ? r_bufPc    : r_pc;

    // Responses are only ever consumed in WAIT, which also drops stale post-reset ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ISSUE;
            r_pc       <= RESET_PC;
            r_kill     <= 1'b0;
            r_bufInstr <= '0;
            r_bufPc    <= '0;
        end else begin
            case (r_state)
                ISSUE: begin
                    if (redirect) begin
                        r_pc <= w_redirPc;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect && imem_rvalid) begin
                        r_pc    <= w_redirPc;
                        r_kill  <= 1'b0;
                        r_state <= ISSUE;
                    end else if (redirect) begin
                        r_pc   <= w_redirPc;
                        r_kill <= 1'b1;
                    end else if (imem_rvalid && r_kill) begin
                        r_kill  <= 1'b0;
                        r_state <= ISSUE;
                    end else if (imem_rvalid) begin
                        r_pc <= w_pcInc;
                        if (w_ifIdFree) begin
                            r_state <= ISSUE;
                        end else begin
                            r_bufInstr <= imem_rdata;
                            r_bufPc    <= r_pc;
                            r_state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        r_pc    <= w_redirPc;
                        r_state <= ISSUE;
                    end else if (!stall_d) begin
                        r_state <= ISSUE;
                    end
                end
                default: begin
                    r_state <= ISSUE;
                end
            endcase
        end
    end

    if_id_reg u_ifId (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (redirect),
        .i_load  (w_load),
        .i_stall (stall_d),
        .i_instr (w_loadInstr),
        .i_pc    (w_loadPc),
        .o_valid (if_valid),
        .o_instr (if_instr),
        .o_pc    (if_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a cycle table for the directed cases,
// a stream-level reference model for latency/random runs, and a PC-wrap instance.

module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;

    logic        wReset_n;
    logic        wReq;
    logic [63:0] wAddr;
    logic        wRvalid;
    logic [31:0] wRdata;
    logic        wStall;
    logic        wRedirect;
    logic [63:0] wRedirectPc;
    logic        wValid;
    logic [31:0] wInstr;
    logic [63:0] wPc;

    int testsRun;
    int testsFailed;

    fetch_unit #(.RESET_PC(64'h0)) dut (
        .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall_d(stall_d),
        .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc)
    );

    fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dutWrap (
        .clk(clk), .reset_n(wReset_n), .imem_req(wReq), .imem_addr(wAddr),
        .imem_rvalid(wRvalid), .imem_rdata(wRdata), .stall_d(wStall),
        .redirect(wRedirect), .redirect_pc(wRedirectPc), .if_valid(wValid),
        .if_instr(wInstr), .if_pc(wPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [63:0] rpc;
        logic        eReq;
        logic [63:0] eAddr;
        logic        eValid;
        logic [63:0] ePc;
        logic [31:0] eInstr;
    } vec_t;

    vec_t vecs[$];

    // Memory model and expected instruction stream
    logic        memBusy;
    logic [63:0] memAddr;
    int          memLeft;
    int          fixedLat;
    logic        randomIn;
    logic [63:0] expPc;
    int          accepted;
    int          reqCycles[$];
    logic        prevHold;
    logic [63:0] prevPc;
    logic [31:0] prevInstr;

    function automatic vec_t mkVec(logic rv, logic [31:0] rd, logic st, logic rdr,
                                   logic [63:0] rp, logic eq, logic [63:0] ea,
                                   logic ev, logic [63:0] ep, logic [31:0] ei);
        vec_t v;
        v.rv = rv; v.rdata = rd; v.stall = st; v.redir = rdr; v.rpc = rp;
        v.eReq = eq; v.eAddr = ea; v.eValid = ev; v.ePc = ep; v.eInstr = ei;
        return v;
    endfunction

    function automatic logic [31:0] memWord(input logic [63:0] a);
        return (a[31:0] * 32'h0001_0003) ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rd, input logic st,
                                 input logic rdr, input logic [63:0] rp);
        imem_rvalid = rv;
        imem_rdata  = rd;
        stall_d     = st;
        redirect    = rdr;
        redirect_pc = rp;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("resetState", 192'({imem_req, if_valid, if_pc, if_instr, imem_addr}), 192'(0));
        @(negedge clk);
        reset_n  = 1'b1;
        memBusy  = 1'b0;
        memLeft  = 0;
        memAddr  = 64'h0;
        expPc    = 64'h0;
        accepted = 0;
        prevHold = 1'b0;
        reqCycles.delete();
    endtask

    // One cycle against the memory model; entered and left at a falling edge
    task automatic modelCycle(input int cyc);
        logic        rv;
        logic [31:0] rd;
        logic        st;
        logic        rdr;
        logic [63:0] rp;
        rv = 1'b0; rd = 32'h0; st = 1'b0; rdr = 1'b0; rp = 64'h0;
        if (memBusy) begin
            memLeft--;
            if (memLeft == 0) begin
                rv = 1'b1;
                rd = memWord(memAddr);
                memBusy = 1'b0;
            end
        end
        if (randomIn) begin
            st  = ($urandom_range(0, 9) < 3);
            rdr = ($urandom_range(0, 19) == 0);
            rp  = {32'h0, $urandom};
        end
        applyStimulus(rv, rd, st, rdr, rp);
        #1;
        if (prevHold)
            checkOutput("holdIfId", 192'({if_valid, if_pc, if_instr}), 192'({1'b1, prevPc, prevInstr}));
        if (imem_req) begin
            checkOutput("oneOutstanding", 192'({memBusy, imem_addr[1:0]}), 192'(0));
            memBusy = 1'b1;
            memAddr = imem_addr;
            memLeft = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 3));
            reqCycles.push_back(cyc);
        end
        if (redirect) begin
            expPc = redirect_pc & ~64'h3;
        end else if (if_valid && !stall_d) begin
            checkOutput("deliveredPc", 192'(if_pc), 192'(expPc));
            checkOutput("deliveredInstr", 192'(if_instr), 192'(memWord(expPc)));
            expPc = expPc + 64'd4;
            accepted++;
        end
        prevHold  = stall_d & if_valid & ~redirect;
        prevPc    = if_pc;
        prevInstr = if_instr;
        @(negedge clk);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        fixedLat    = 1;
        randomIn    = 1'b0;
        wReset_n    = 1'b0;
        wRvalid     = 1'b0;
        wRdata      = 32'h0;
        wStall      = 1'b0;
        wRedirect   = 1'b0;
        wRedirectPc = 64'h0;

        // Directed cycle table with a 1-cycle memory: stall/HOLD, redirects in WAIT, HOLD and ISSUE
        vecs.push_back(mkVec(0, 32'h0,        0, 0, 64'h0,   1, 64'h0,   0, 64'h0,   32'h0));
        vecs.push_back(mkVec(1, 32'hF8400000, 0, 0, 64'h0,   0, 64'h0,   0, 64'h0,   32'h0));
        vecs.push_back(mkVec(0, 32'h0,        0, 0, 64'h0,   1, 64'h4,   1, 64'h0,   32'hF8400000));
        vecs.push_back(mkVec(1, 32'h11111111, 0, 0, 64'h0,   0, 64'h4,   0, 64'h0,   32'hF8400000));
        vecs.push_back(mkVec(0, 32'h0,        1, 0, 64'h0,   1, 64'h8,   1, 64'h4,   32'h11111111));
        vecs.push_back(mkVec(1, 32'h22222222, 1, 0, 64'h0,   0, 64'h8,   1, 64'h4,   32'h11111111));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mkVec(0, 32'h0,    1, 0, 64'h0,   0, 64'hC,   1, 64'h4,   32'h11111111));
        vecs.push_back(mkVec(0, 32'h0,        0, 0, 64'h0,   0, 64'hC,   1, 64'h4,   32'h11111111));
        vecs.push_back(mkVec(0, 32'h0,        1, 0, 64'h0,   1, 64'hC,   1, 64'h8,   32'h22222222));
        vecs.push_back(mkVec(0, 32'h0,        1, 1, 64'h103, 0, 64'hC,   1, 64'h8,   32'h22222222));
        vecs.push_back(mkVec(0, 32'h0,        0, 0, 64'h0,   0, 64'h100, 0, 64'h8,   32'h22222222));
        vecs.push_back(mkVec(1, 32'h33333333, 0, 0, 64'h0,   0, 64'h100, 0, 64'h8,   32'h22222222));
        vecs.push_back(mkVec(0, 32'h0,        0, 0, 64'h0,   1, 64'h100, 0, 64'h8,   32'h22222222));
        vecs.push_back(mkVec(1, 32'h44444444, 0, 0, 64'h0,   0, 64'h100, 0, 64'h8,   32'h22222222));
        vecs.push_back(mkVec(0, 32'h0,        1, 0, 64'h0,   1, 64'h104, 1, 64'h100, 32'h44444444));
        vecs.push_back(mkVec(1, 32'h55555555, 1, 1, 64'h200, 0, 64'h104, 1, 64'h100, 32'h44444444));
        vecs.push_back(mkVec(0, 32'h0,        0, 0, 64'h0,   1, 64'h200, 0, 64'h100, 32'h44444444));
        vecs.push_back(mkVec(1, 32'h66666666, 0, 0, 64'h0,   0, 64'h200, 0, 64'h100, 32'h44444444));
        vecs.push_back(mkVec(0, 32'h0,        1, 0, 64'h0,   1, 64'h204, 1, 64'h200, 32'h66666666));
        vecs.push_back(mkVec(1, 32'h77777777, 1, 0, 64'h0,   0, 64'h204, 1, 64'h200, 32'h66666666));
        vecs.push_back(mkVec(0, 32'h0,        1, 1, 64'h300, 0, 64'h208, 1, 64'h200, 32'h66666666));
        vecs.push_back(mkVec(0, 32'h0,        0, 0, 64'h0,   1, 64'h300, 0, 64'h200, 32'h66666666));
        vecs.push_back(mkVec(1, 32'h88888888, 0, 0, 64'h0,   0, 64'h300, 0, 64'h200, 32'h66666666));
        vecs.push_back(mkVec(0, 32'h0,        0, 1, 64'h400, 0, 64'h304, 1, 64'h300, 32'h88888888));
        vecs.push_back(mkVec(0, 32'h0,        0, 0, 64'h0,   1, 64'h400, 0, 64'h300, 32'h88888888));

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rv, vecs[i].rdata, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            #1;
            checkOutput($sformatf("vec%0d", i),
                        192'({imem_req, imem_addr, if_valid, if_pc, if_instr}),
                        192'({vecs[i].eReq, vecs[i].eAddr, vecs[i].eValid, vecs[i].ePc, vecs[i].eInstr}));
            @(negedge clk);
        end

        // 3-cycle memory: a request every 4 cycles, every instruction delivered once
        doReset();
        fixedLat = 3;
        randomIn = 1'b0;
        for (int c = 0; c < 40; c++) modelCycle(c);
        checkOutput("lat3ReqCount", 192'(reqCycles.size()), 192'(10));
        for (int k = 1; k < reqCycles.size(); k++)
            checkOutput("lat3ReqSpacing", 192'(reqCycles[k] - reqCycles[k-1]), 192'(4));
        checkOutput("lat3Delivered", 192'(accepted), 192'(9));

        // Random latency, stalls and redirects against the stream model
        doReset();
        fixedLat = 0;
        randomIn = 1'b1;
        for (int c = 0; c < 800; c++) modelCycle(c);
        checkOutput("randomProgress", 192'(accepted >= 40), 192'(1));
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);

        // PC wrap and reset asserted while waiting for a response
        #1;
        checkOutput("wrapInReset", 192'({wReq, wValid, wAddr}), 192'({1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC}));
        @(negedge clk);
        wReset_n = 1'b1;
        #1;
        checkOutput("wrapFirstReq", 192'({wReq, wAddr}), 192'({1'b1, 64'hFFFF_FFFF_FFFF_FFFC}));
        @(negedge clk);
        wRvalid = 1'b1; wRdata = 32'hAAAA0001;
        #1;
        checkOutput("wrapWaitNoReq", 192'(wReq), 192'(0));
        @(negedge clk);
        wRvalid = 1'b0;
        #1;
        checkOutput("wrapToZero", 192'({wReq, wAddr, wValid, wPc, wInstr}),
                    192'({1'b1, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hAAAA0001}));
        @(negedge clk);
        wReset_n = 1'b0;
        #1;
        checkOutput("midWaitReset", 192'({wReq, wAddr, wValid, wPc, wInstr}),
                    192'({1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 32'h0}));
        @(negedge clk);
        wRvalid = 1'b1; wRdata = 32'hBBBB0002;
        #1;
        checkOutput("reqHeldInReset", 192'({wReq, wValid}), 192'(0));
        @(negedge clk);
        wReset_n = 1'b1; wRvalid = 1'b1; wRdata = 32'hCCCC0003;
        #1;
        checkOutput("afterResetReq", 192'({wReq, wAddr, wValid}), 192'({1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0}));
        @(negedge clk);
        wRvalid = 1'b0;
        #1;
        checkOutput("staleRespDropped", 192'({wReq, wValid}), 192'(0));
        @(negedge clk);
        wRvalid = 1'b1; wRdata = 32'hDDDD0004;
        @(negedge clk);
        wRvalid = 1'b0;
        #1;
        checkOutput("lateRespIgnored", 192'({wValid, wPc, wInstr}),
                    192'({1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hDDDD0004}));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch stage with the IF/ID pipeline register.
- Holds the PC and issues one instruction-memory read at a time.
- Absorbs variable memory latency and supports decode back-pressure and branch redirect.
- Its `if_instr` output feeds the decode-stage sign extender and control decoder; `redirect`/`redirect_pc` come from branch resolution in a later stage.

## Interface

Parameters:
- `RESET_PC`, default 64'h0: PC loaded on reset.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `imem_req`, out, 1: read request; the memory accepts it in the cycle it is asserted.
- `imem_addr`, out, 64: request address (byte address, word aligned).
- `imem_rvalid`, in, 1: response valid. Responses arrive at least 1 cycle after the request, in order, with at most one outstanding.
- `imem_rdata`, in, 32: instruction word, valid with `imem_rvalid`.
- `stall_d`, in, 1: decode cannot accept; IF/ID contents must hold.
- `redirect`, in, 1: taken branch or flush.
- `redirect_pc`, in, 64: new fetch address, sampled when `redirect`=1.
- `if_valid`, out, 1: IF/ID holds a valid instruction.
- `if_instr`, out, 32: IF/ID instruction word.
- `if_pc`, out, 64: address of `if_instr`.

## Operation

Registers:
- `pc`: the address being fetched.
- `state`: one of ISSUE, WAIT, HOLD.
- `kill`: discard the next response.
- A one-entry buffer (`buf_instr`, `buf_pc`).

State transitions:
- **ISSUE**
  - `imem_req` = `~redirect`; `imem_addr` = `pc`.
  - If `redirect`: `pc`<=`redirect_pc`, stay in ISSUE, no request.
  - Otherwise go to WAIT.
- **WAIT**, no request. Checked in priority order:
  1. `redirect` & `imem_rvalid`: drop the response, `pc`<=`redirect_pc`, `kill`<=0, go to ISSUE.
  2. `redirect` alone: `pc`<=`redirect_pc`, `kill`<=1, stay in WAIT.
  3. `imem_rvalid` & `kill`: drop the response, `kill`<=0, go to ISSUE.
  4. `imem_rvalid` & (`~if_valid` | `~stall_d`): load IF/ID with {`imem_rdata`, `pc`}, `pc`<=`pc`+4, go to ISSUE.
  5. `imem_rvalid` otherwise: load the buffer with {`imem_rdata`, `pc`}, `pc`<=`pc`+4, go to HOLD.
- **HOLD**
  - If `redirect`: discard the buffer, `pc`<=`redirect_pc`, go to ISSUE.
  - Else if `~stall_d`: move the buffer into IF/ID, go to ISSUE.

IF/ID register:
- `redirect` forces `if_valid`<=0. It has priority over `stall_d` and over any load.
- `stall_d` & `if_valid` & no redirect: hold all IF/ID fields.
- `~stall_d` with nothing to load: `if_valid`<=0. `if_instr` and `if_pc` keep their last value.

Arithmetic and widths:
- `pc`+4 is a 64-bit add with wrap modulo 2^64; no overflow flag.
- `redirect_pc[1:0]` is ignored and forced to 00.

## Timing

- Reset values: `pc`=`RESET_PC`, `state`=ISSUE, `kill`=0, buffer=0, `if_valid`=0, `if_instr`=0, `if_pc`=0.
- Outputs while `reset_n`=0: `imem_req`=0.
- `imem_req` is 1 in the first cycle after `reset_n` rises.
- Latency, 1-cycle memory: request in cycle N, `imem_rvalid` in N+1, `if_valid`=1 from N+2.
- Peak throughput: one instruction per 2 cycles.
- `imem_req` depends combinationally on `state` and `redirect` only. All other outputs are registered.
- Reset asserted mid-operation: all state clears immediately.
  - A response arriving after `reset_n` rises but before the first request must be ignored.
  - Implement this by setting `kill`=0 and requiring WAIT before any response is accepted; responses outside WAIT are dropped.

## Structure

- Package `fetch_pkg` contains:
  - Enum `fetch_state_t` {ISSUE, WAIT, HOLD}.
  - `INSTR_BYTES`=4.
  - `PC_W`=64.
  - `INSTR_W`=32.
- Sub-module `if_id_reg` (valid/instr/pc with load, hold, flush) is instantiated once.
- The FSM, `pc`, `kill` and the buffer stay in `fetch_unit`.

## Test plan

1. Reset release, memory with 1-cycle latency returning 0xF8400000, `RESET_PC`=0 -> `imem_addr` sequence 0, 4, 8. First `if_valid` two cycles after the first request, with `if_pc`=0 and `if_instr`=0xF8400000.
2. 3-cycle memory latency -> `imem_req` pulses every 4 cycles; no duplicate or dropped instructions.
3. `stall_d`=1 for 6 cycles while IF/ID is valid:
   - The next response goes to the buffer and the FSM enters HOLD.
   - No further requests while stalled.
   - On release, the buffered instruction appears with the correct `if_pc`, and fetch resumes at `pc`+4.
4. `redirect`=1 with `redirect_pc`=0x100 during WAIT, response 2 cycles later:
   - The response is discarded.
   - The next `imem_addr`=0x100.
   - `if_valid` drops the cycle after the redirect.
5. `redirect` and `imem_rvalid` in the same cycle; then, as a separate case, `redirect` together with `stall_d` in HOLD -> both responses are discarded, IF/ID is flushed, and the next request goes to `redirect_pc`.
6. `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC, then assert `reset_n`=0 mid-WAIT:
   - Fetch addresses wrap to 0 after 0xFFFF_FFFF_FFFF_FFFC.
   - The mid-WAIT reset clears all outputs immediately, and the late response is ignored.
